sd_spi_master: RTL and testbench
================================

SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the SCK divider register.
REQ-002 SHALL have parameter DIV_RST, default 8'd13: divider value loaded at reset, giving the slow clock for card init.
REQ-003 SHALL have port clk_sys, in, 1: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port reset_n, in, 1: reset, synchronous, active-low.
REQ-005 SHALL have port ce, in, 1: clock enable (28 MHz rate); all SPI timing advances only on ce=1 cycles.
REQ-006 SHALL have port start, in, 1: one-cycle request to transfer tx_data.
REQ-007 SHALL have port tx_data, in, 8: byte to send.
REQ-008 SHALL have port rx_data, out, 8: last byte received.
REQ-009 SHALL have port busy, out, 1: transfer in progress.
REQ-010 SHALL have port done, out, 1: one-cycle pulse marking transfer complete.
REQ-011 SHALL have port cs_we, in, 1: strobe that writes chip select.
REQ-012 SHALL have port cs_din, in, 1: chip select value; 1 deselects the card.
REQ-013 SHALL have port div_we, in, 1: strobe that writes the divider.
REQ-014 SHALL have port div_din, in, DIV_W: new divider value.
REQ-015 SHALL have port sd_clk, out, 1: SPI clock.
REQ-016 SHALL have port sd_si, out, 1: MOSI, master to card.
REQ-017 SHALL have port sd_so, in, 1: MISO, card to master.
REQ-018 SHALL have port sd_cs_n, out, 1: active-low card select.

Function
REQ-019 SHALL use SPI mode 0, MSB first: sd_clk idles 0, MISO is sampled on the rising sd_clk, MOSI changes on the falling sd_clk.
REQ-020 SHALL hold each sd_clk phase (low or high) for div+1 ce ticks; one byte SHALL take 16*(div+1) ce ticks.
REQ-021 SHALL implement FSM states IDLE, LOW, HIGH, FIN; the state SHALL advance only when ce=1 and the phase counter reaches div.
REQ-022 In IDLE, start=1 SHALL: load the shift register with tx_data, drive sd_si=tx_data[7], set busy=1 in the next cycle, and enter LOW with bit count 0.
REQ-023 At the end of LOW, the block SHALL set sd_clk=1, shift sd_so into the receive register LSB, and enter HIGH.
REQ-024 At the end of HIGH, the block SHALL set sd_clk=0; if bit count < 7, it SHALL increment the count, present the next MOSI bit, and enter LOW; if bit count = 7, it SHALL enter FIN.
REQ-025 FIN SHALL last one clk_sys cycle, independent of ce: rx_data is updated with the receive register, done=1, busy=0, sd_si=1, and the state returns to IDLE.
REQ-026 start while busy=1 or in FIN SHALL be ignored, with no queuing.
REQ-027 cs_we SHALL update sd_cs_n one cycle after the strobe when not busy; when busy it SHALL be ignored.
REQ-028 div_we SHALL update the divider only when not busy; when busy it SHALL be ignored.
REQ-029 If cs_we and start arrive in the same IDLE cycle, the CS update SHALL take effect in the same cycle that the transfer begins.
REQ-030 The phase counter SHALL be DIV_W bits wide, compare with == div, and never wrap past div; div=0 SHALL give sd_clk at ce/2.
REQ-031 rx_data SHALL hold its value between transfers and change only in FIN.
REQ-032 sd_si SHALL be 1 whenever the block is not in LOW or HIGH.

Reset
REQ-033 When reset_n=0 at a clock edge, the block SHALL set: state=IDLE, sd_cs_n=1, sd_clk=0, sd_si=1, busy=0, done=0, rx_data=8'hFF, divider=DIV_RST, phase counter=0, bit count=0.
REQ-034 reset_n=0 mid-transfer SHALL abort immediately with no done pulse; after reset, outputs SHALL equal the REQ-033 values.

Verification
REQ-035 Test: div=0, ce=1 always, tx_data=8'hA5, MISO model returns 8'h3C. Required: exactly 8 sd_clk rising edges; MOSI bits 1,0,1,0,0,1,0,1; done pulses 16 cycles (+FIN) after start; rx_data=8'h3C.
REQ-036 Test: ce asserted every 3rd cycle, div=1, 8'hFF out. Required: each sd_clk phase lasts 6 clk_sys cycles; byte time 96 cycles.
REQ-037 Test: second start, div_we and cs_we applied during a transfer. Required: all ignored; exactly one done; sd_cs_n and div unchanged.
REQ-038 Test: cs_we with cs_din=0 and start in the same idle cycle. Required: sd_cs_n=0 before the first sd_clk rising edge.
REQ-039 Test: reset_n=0 after the 4th sd_clk rise. Required: next cycle sd_clk=0, sd_si=1, sd_cs_n=1, busy=0, rx_data=8'hFF, no done pulse.
REQ-040 Test: after reset, no div_we, one transfer. Required: phase length = DIV_RST+1 = 14 ce ticks.

Source files
------------

// File: rtl/sd_spi_master.sv
`timescale 1ns/1ps
// SPI-mode-0 byte engine for an SD card: MSB first, programmable SCK divider,
// chip-select register, and a ce-gated phase counter for each SCK half-period.
module sd_spi_master #(
  parameter int unsigned      DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = 8'd13
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             start,
  input  logic [7:0]       tx_data,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             done,
  input  logic             cs_we,
  input  logic             cs_din,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_din,
  output logic             sd_clk,
  output logic             sd_si,
  input  logic             sd_so,
  output logic             sd_cs_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             sd_clk_q, sd_clk_d;
  logic             sd_si_q, sd_si_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;

  // A half-period ends on the ce tick where the counter has reached the divider.
  assign phase_end = ce && (phase_q == div_q);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves
    // one unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sd_clk_d  = sd_clk_q;
    sd_si_d   = sd_si_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Configuration writes are only honoured between transfers.
    if (!busy_q) begin
      if (cs_we)  cs_n_d = cs_din;
      if (div_we) div_d  = div_din;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d = tx_data[6:0];
          sd_si_d = tx_data[7];
          busy_d  = 1'b1;
          bit_d   = 3'd0;
          phase_d = '0;
          state_d = LOW;
        end
      end

      LOW: begin
        if (phase_end) begin
          phase_d  = '0;
          sd_clk_d = 1'b1;
          rx_sr_d  = {rx_sr_q[6:0], sd_so};
          state_d  = HIGH;
        end else if (ce) begin
          phase_d = phase_q + 1'b1;
        end
      end

      HIGH: begin
        if (phase_end) begin
          phase_d  = '0;
          sd_clk_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            sd_si_d = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
            state_d = LOW;
          end else begin
            // Result and completion flags become visible for the single FIN cycle.
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            sd_si_d   = 1'b1;
            state_d   = FIN;
          end
        end else if (ce) begin
          phase_d = phase_q + 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= DIV_RST;
      phase_q   <= '0;
      bit_q     <= 3'd0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= 8'hFF;
      sd_clk_q  <= 1'b0;
      sd_si_q   <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sd_clk_q  <= sd_clk_d;
      sd_si_q   <= sd_si_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sd_clk  = sd_clk_q;
  assign sd_si   = sd_si_q;
  assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_sd_spi_master.sv
`timescale 1ns/1ps
// Directed + randomized bench for sd_spi_master: a card model on the SPI pins and
// an arithmetic timing model (phase = (div+1) ce ticks, byte = 16 phases).
module tb_sd_spi_master;

  localparam int DIV_RST_I = 13;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce = 1'b1;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       cs_we;
  logic       cs_din;
  logic       div_we;
  logic [7:0] div_din;
  logic       sd_clk;
  logic       sd_si;
  logic       sd_so;
  logic       sd_cs_n;

  sd_spi_master #(
    .DIV_W  (8),
    .DIV_RST(8'd13)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ce     (ce),
    .start  (start),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done),
    .cs_we  (cs_we),
    .cs_din (cs_din),
    .div_we (div_we),
    .div_din(div_din),
    .sd_clk (sd_clk),
    .sd_si  (sd_si),
    .sd_so  (sd_so),
    .sd_cs_n(sd_cs_n)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Edge index: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ce is high at edge m exactly when (m-1) is a multiple of ce_period.
  int ce_period = 1;
  always @(posedge clk_sys) begin
    #1;
    ce = (cyc % ce_period == 0);
  end

  // Reference state for the configuration registers.
  int   cur_div = DIV_RST_I;
  logic cur_cs  = 1'b1;

  // Card model: samples MOSI on each sd_clk rise, shifts MISO out MSB first.
  logic       sd_clk_prev = 1'b0;
  logic       mosi_q[$];
  logic       cs_q[$];
  int         edge_q[$];
  int         done_total = 0;
  int         done_cyc   = 0;
  logic [7:0] miso_byte  = 8'hFF;
  int         rise_base  = 0;

  always @(negedge clk_sys) begin
    int k;
    if (sd_clk !== sd_clk_prev) begin
      edge_q.push_back(cyc);
      if (sd_clk === 1'b1) begin
        mosi_q.push_back(sd_si);
        cs_q.push_back(sd_cs_n);
      end
    end
    sd_clk_prev = sd_clk;
    if (done === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
    k = mosi_q.size() - rise_base;
    sd_so = (k >= 0 && k < 8) ? miso_byte[7 - k] : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are read just after the falling edge.
  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic set_cs(input logic v);
    cs_we  = 1'b1;
    cs_din = v;
    tick();
    cs_we  = 1'b0;
    cur_cs = v;
    check("cs_update", sd_cs_n, v);
  endtask

  task automatic set_div(input int v);
    div_we  = 1'b1;
    div_din = 8'(v);
    tick();
    div_we  = 1'b0;
    cur_div = v;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] miso, input int p,
                      input bit with_cs, input logic cs_val, input bit meddle);
    int         start_edge, rb, eb, db, budget, n, bad, unit;
    bit         meddled;
    logic [7:0] mosi;
    unit      = (cur_div + 1) * p;
    ce_period = p;
    miso_byte = miso;
    rb        = mosi_q.size();
    eb        = edge_q.size();
    db        = done_total;
    rise_base = rb;
    tick();
    while (cyc % p != 0) tick();
    tx_data = tx;
    start   = 1'b1;
    if (with_cs) begin
      cs_we  = 1'b1;
      cs_din = cs_val;
      cur_cs = cs_val;
    end
    start_edge = cyc + 1;
    tick();
    start = 1'b0;
    cs_we = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("cs_at_start", sd_cs_n, cur_cs);

    budget  = 16 * unit + 20;
    n       = 0;
    meddled = 1'b0;
    while (done_total == db && n < budget) begin
      if (meddle && !meddled && (mosi_q.size() - rb == 2)) begin
        start   = 1'b1;
        tx_data = ~tx;
        div_we  = 1'b1;
        div_din = 8'(cur_div + 1);
        cs_we   = 1'b1;
        cs_din  = ~cur_cs;
        meddled = 1'b1;
        tick();
        start  = 1'b0;
        div_we = 1'b0;
        cs_we  = 1'b0;
      end else begin
        tick();
      end
      n++;
    end

    check("done_seen", done_total - db, 1);
    check("done_latency", done_cyc - start_edge, 16 * unit);
    check("busy_in_fin", busy, 1'b0);
    check("si_in_fin", sd_si, 1'b1);
    check("rx_data", rx_data, miso);
    check("rises", mosi_q.size() - rb, 8);
    if (mosi_q.size() >= rb + 8) begin
      mosi = '0;
      for (int i = 0; i < 8; i++) mosi = {mosi[6:0], mosi_q[rb + i]};
      check("mosi_bits", mosi, tx);
      check("cs_first_rise", cs_q[rb], cur_cs);
    end
    check("toggles", edge_q.size() - eb, 16);
    if (edge_q.size() >= eb + 16) begin
      check("first_rise", edge_q[eb] - start_edge, unit);
      bad = 0;
      for (int i = 1; i < 16; i++)
        if (edge_q[eb + i] - edge_q[eb + i - 1] != unit) bad++;
      check("phase_len_bad", bad, 0);
    end

    repeat (4) tick();
    check("one_done", done_total - db, 1);
    check("idle_busy", busy, 1'b0);
    check("idle_clk", sd_clk, 1'b0);
    check("idle_si", sd_si, 1'b1);
    check("rx_hold", rx_data, miso);
    check("cs_hold", sd_cs_n, cur_cs);
  endtask

  initial begin
    int rb, db, n;
    reset_n = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;
    cs_we   = 1'b0;
    cs_din  = 1'b1;
    div_we  = 1'b0;
    div_din = 8'h00;
    repeat (3) tick();

    check("rst_clk", sd_clk, 1'b0);
    check("rst_si", sd_si, 1'b1);
    check("rst_cs", sd_cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, 8'hFF);
    reset_n = 1'b1;
    tick();

    // Reset divider: 14 ce ticks per phase.
    xfer(8'h5A, 8'hC3, 1, 1'b0, 1'b0, 1'b0);

    set_cs(1'b0);
    set_div(0);
    xfer(8'hA5, 8'h3C, 1, 1'b0, 1'b0, 1'b0);

    set_div(1);
    xfer(8'hFF, 8'h96, 3, 1'b0, 1'b0, 1'b0);

    // Chip select written in the same idle cycle as start.
    set_cs(1'b1);
    xfer(8'h81, 8'h7E, 1, 1'b1, 1'b0, 1'b0);

    // Start, divider and chip-select writes during a transfer are ignored.
    xfer(8'h33, 8'hCC, 2, 1'b0, 1'b0, 1'b1);
    xfer(8'h0F, 8'hE1, 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      set_div($urandom_range(0, 3));
      xfer(8'($urandom), 8'($urandom), $urandom_range(1, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Abort after the 4th sd_clk rise.
    set_cs(1'b0);
    ce_period = 1;
    miso_byte = 8'h55;
    rb        = mosi_q.size();
    rise_base = rb;
    db        = done_total;
    tick();
    tx_data = 8'($urandom);
    start   = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    while (mosi_q.size() - rb < 4 && n < 500) begin
      tick();
      n++;
    end
    check("abort_at_rise4", mosi_q.size() - rb, 4);
    reset_n = 1'b0;
    tick();
    check("abort_clk", sd_clk, 1'b0);
    check("abort_si", sd_si, 1'b1);
    check("abort_cs", sd_cs_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rx", rx_data, 8'hFF);
    check("abort_done", done, 1'b0);
    reset_n = 1'b1;
    cur_div = DIV_RST_I;
    cur_cs  = 1'b1;
    repeat (5) tick();
    check("abort_no_done", done_total - db, 0);

    xfer(8'($urandom), 8'($urandom), 1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
